// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word fetches, buffers responses, feeds the IF/ID register.
// Latency: a response reaches id_state on the edge after imem_rvalid when the buffer is empty.
// Backpressure: stall holds IF/ID, fetching pauses once buffer plus in-flight fills capacity.
// Optional feature macro: IF_PREFETCH_EN (2-entry buffer, 2 requests in flight; else 1 and 1).

package PipelineReg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } ID_STATE;
endpackage

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ready,
    input  logic                 imem_rvalid,
    input  logic [31:0]          imem_rdata,
    input  logic                 stall,
    input  logic                 jmp,
    input  logic [31:0]          jmp_pc,
    output PipelineReg::ID_STATE id_state,
    output logic                 id_valid
);

`ifdef IF_PREFETCH_EN
    localparam int BUF_DEPTH    = 2;
    localparam int MAX_INFLIGHT = 2;
`else
    localparam int BUF_DEPTH    = 1;
    localparam int MAX_INFLIGHT = 1;
`endif

    localparam int CNT_W  = 2;
    localparam int OCC_W  = 3;
    // Drop-pending responses are bounded only by how many redirects land
    // before the memory answers; 4 bits covers any realistic burst.
    localparam int DROP_W = 4;

    localparam logic [CNT_W-1:0] INFLIGHT_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [OCC_W-1:0] BUF_CAP      = OCC_W'(BUF_DEPTH);
    localparam bit               TWO_ENTRY    = (BUF_DEPTH == 2);
    localparam logic [31:0]      RESET_PC_A   = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    fetch_state_t         state, state_n;
    logic [31:0]          fetch_pc;
    logic [31:0]          rsp_pc;
    logic [31:0]          rsp_pc_next;
    logic [31:0]          jmp_tgt;
    logic [CNT_W-1:0]     inflight_cnt, inflight_n;
    logic [CNT_W-1:0]     buf_cnt, buf_n;
    logic [DROP_W-1:0]    drop_cnt, drop_n;
    logic [OCC_W-1:0]     occ_n;
    PipelineReg::ID_STATE buf_mem [0:1];
    logic                 wr_ptr, rd_ptr;

    logic accept;
    logic rsp_live;
    logic rsp_drop;
    logic take;
    logic buf_empty;
    logic bypass;
    logic push;
    logic pop;

    // Request is held off while reset is high so nothing is issued until it drops.
    assign imem_req    = (state == FETCH) && !reset;
    assign imem_addr   = fetch_pc;
    assign accept      = imem_req && imem_ready;
    assign jmp_tgt     = jmp_pc & 32'hFFFF_FFFC;
    assign rsp_pc_next = rsp_pc + 32'd4;

    // A response is dropped while any redirect-orphaned request is still owed.
    assign rsp_drop  = imem_rvalid && (drop_cnt != '0);
    assign rsp_live  = imem_rvalid && (drop_cnt == '0);
    assign take      = !stall && !jmp;
    assign buf_empty = (buf_cnt == '0);
    // Empty buffer lets a live response go straight to IF/ID, saving a cycle.
    assign bypass    = rsp_live && take && buf_empty;
    assign push      = rsp_live && !jmp && !bypass;
    assign pop       = take && !buf_empty;

    // Next counter values and FSM state; the state follows the resulting occupancy.
    always_comb begin
        inflight_n = inflight_cnt;
        drop_n     = drop_cnt;
        buf_n      = buf_cnt;
        state_n    = state;
        occ_n      = '0;
        if (jmp) begin
            // Everything still owed by memory, including a request accepted on
            // this edge, becomes drop-pending; a response arriving now is discarded.
            inflight_n = '0;
            buf_n      = '0;
            drop_n     = drop_cnt + DROP_W'(inflight_cnt) + DROP_W'(accept)
                         - DROP_W'(imem_rvalid);
            state_n    = FETCH;
        end else begin
            inflight_n = inflight_cnt + CNT_W'(accept) - CNT_W'(rsp_live);
            drop_n     = drop_cnt - DROP_W'(rsp_drop);
            buf_n      = buf_cnt + CNT_W'(push) - CNT_W'(pop);
            occ_n      = {1'b0, inflight_n} + {1'b0, buf_n};
            if (inflight_n >= INFLIGHT_MAX) begin
                state_n = WAIT;
            end else if (occ_n >= BUF_CAP) begin
                state_n = HOLD;
            end else begin
                state_n = FETCH;
            end
        end
    end

    // FSM state and occupancy counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            inflight_cnt <= '0;
            drop_cnt     <= '0;
            buf_cnt      <= '0;
        end else begin
            state        <= state_n;
            inflight_cnt <= inflight_n;
            drop_cnt     <= drop_n;
            buf_cnt      <= buf_n;
        end
    end

    // Fetch address: redirect wins, otherwise advance by a word per accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC_A;
        end else if (jmp) begin
            fetch_pc <= jmp_tgt;
        end else if (accept) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Address of the next live response; responses are in order and contiguous.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_pc <= RESET_PC_A;
        end else if (jmp) begin
            rsp_pc <= jmp_tgt;
        end else if (bypass || push) begin
            rsp_pc <= rsp_pc_next;
        end
    end

    // Prefetch buffer pointers; a redirect empties the buffer.
    always_ff @(posedge clk) begin
        if (reset || jmp) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= TWO_ENTRY ? ~wr_ptr : 1'b0;
            end
            if (pop) begin
                rd_ptr <= TWO_ENTRY ? ~rd_ptr : 1'b0;
            end
        end
    end

    // Prefetch buffer storage holds {pc + 4, instruction} ready for IF/ID.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= {rsp_pc_next, imem_rdata};
        end
    end

    // IF/ID register: redirect bubbles, stall holds, else head, bypass or bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_state <= {RESET_PC_A, NOP_INSN};
            id_valid <= 1'b0;
        end else if (jmp) begin
            id_state.instruction <= NOP_INSN;
            id_valid             <= 1'b0;
        end else if (!stall) begin
            if (pop) begin
                id_state <= buf_mem[rd_ptr];
                id_valid <= 1'b1;
            end else if (bypass) begin
                id_state <= {rsp_pc_next, imem_rdata};
                id_valid <= 1'b1;
            end else begin
                id_state.instruction <= NOP_INSN;
                id_valid             <= 1'b0;
            end
        end
    end

endmodule
